// File: rtl/spi_pkg.sv
// Shared state type and default sizing for the SPI command-then-read master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    DELAY,
    RX,
    DONE
  } state_t;

  localparam int unsigned SclkHalfDefault    = 4;
  localparam int unsigned TxBitsDefault      = 8;
  localparam int unsigned RxBitsDefault      = 24;
  localparam int unsigned DelayCyclesDefault = 64;

endpackage

// File: rtl/spi_fsm.sv
// Transaction sequencer: steps IDLE -> TX -> DELAY -> RX -> DONE on datapath strobes and
// produces the datapath controls plus registered chip-select and phase pulses.
module spi_fsm
  import spi_pkg::*;
(
  input  logic clock_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic tx_bits_done_i,
  input  logic delay_last_i,
  input  logic rx_bits_done_i,
  output logic tx_load_o,
  output logic tx_en_o,
  output logic rx_en_o,
  output logic delay_en_o,
  output logic delay_clear_o,
  output logic cs_n_o,
  output logic start_o,
  output logic tx_done_o,
  output logic delay_done_o,
  output logic rx_done_o,
  output logic done_o
);

  state_t state;
  logic   cs_n_q;
  logic   start_q;
  logic   tx_done_q;
  logic   delay_done_q;
  logic   rx_done_q;
  logic   done_q;

  // Load happens on the accepting edge so MOSI carries the MSB from the first TX cycle.
  assign tx_load_o     = (state == IDLE) && start_i;
  assign tx_en_o       = (state == TX);
  assign rx_en_o       = (state == RX);
  assign delay_en_o    = (state == DELAY);
  assign delay_clear_o = (state != DELAY);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cs_n_q       <= 1'b1;
      start_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      delay_done_q <= 1'b0;
      rx_done_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      delay_done_q <= 1'b0;
      rx_done_q    <= 1'b0;
      done_q       <= 1'b0;
      case (state)
        IDLE: begin
          cs_n_q <= 1'b1;
          if (start_i) begin
            state   <= TX;
            cs_n_q  <= 1'b0;
            start_q <= 1'b1;
          end
        end
        TX: begin
          if (tx_bits_done_i) begin
            state     <= DELAY;
            tx_done_q <= 1'b1;
          end
        end
        DELAY: begin
          if (delay_last_i) begin
            state        <= RX;
            delay_done_q <= 1'b1;
          end
        end
        RX: begin
          if (rx_bits_done_i) begin
            state     <= DONE;
            rx_done_q <= 1'b1;
            cs_n_q    <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          cs_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign cs_n_o       = cs_n_q;
  assign start_o      = start_q;
  assign tx_done_o    = tx_done_q;
  assign delay_done_o = delay_done_q;
  assign rx_done_o    = rx_done_q;
  assign done_o       = done_q;

endmodule

// File: rtl/spi.sv
// SPI mode-0 master: sends a command byte, idles SCLK for a fixed delay, then reads a word.
// Holds the SCLK divider, shift registers and delay counter; sequencing lives in spi_fsm.
module spi
  import spi_pkg::*;
#(
  parameter int unsigned SCLK_HALF    = SclkHalfDefault,
  parameter int unsigned TX_BITS      = TxBitsDefault,
  parameter int unsigned RX_BITS      = RxBitsDefault,
  parameter int unsigned DELAY_CYCLES = DelayCyclesDefault
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [TX_BITS-1:0] tx_buffer_i,
  output logic [RX_BITS-1:0] rx_buffer_o,
  input  logic               MISO_i,
  output logic               MOSI_o,
  output logic               CS_o,
  output logic               SCLK_o,
  output logic               done_o,
  output logic               start_o,
  output logic               tx_done_o,
  output logic               delay_done_o,
  output logic               rx_done_o,
  input  logic               tx_en_i,
  input  logic               tx_load_i,
  input  logic               rx_en_i,
  input  logic               delay_en_i,
  input  logic               delay_clear_i
);

  localparam int unsigned PeriodLen = 2 * SCLK_HALF;
  localparam int unsigned MaxBits   = (TX_BITS > RX_BITS) ? TX_BITS : RX_BITS;
  localparam int unsigned CntW      = $clog2(PeriodLen);
  localparam int unsigned BitW      = $clog2(MaxBits + 1);
  localparam int unsigned DlyW      = $clog2(DELAY_CYCLES + 1);

  // Test-hook inputs are intentionally not used; the FSM owns these controls.
  logic unused_test_hooks;
  assign unused_test_hooks = ^{tx_en_i, tx_load_i, rx_en_i, delay_en_i, delay_clear_i};

  logic tx_load, tx_en, rx_en, delay_en, delay_clear;
  logic tx_bits_done, rx_bits_done, delay_last;
  logic shifting, period_end, sclk_rise;

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [DlyW-1:0]    dly_q, dly_d;
  logic [TX_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [RX_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [RX_BITS-1:0] rx_buf_q, rx_buf_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               cs_n;

  assign shifting     = tx_en | rx_en;
  assign period_end   = shifting && (cnt_q == CntW'(PeriodLen - 1));
  assign sclk_rise    = shifting && (cnt_q == CntW'(SCLK_HALF - 1));
  assign tx_bits_done = tx_en && period_end && (bit_q == BitW'(TX_BITS - 1));
  assign rx_bits_done = rx_en && period_end && (bit_q == BitW'(RX_BITS - 1));
  assign delay_last   = delay_en && (dly_q == DlyW'(DELAY_CYCLES - 1));

  // Divider and bit counter; both rest at zero outside TX/RX so each phase starts SCLK-low.
  always_comb begin
    cnt_d = '0;
    bit_d = '0;
    if (shifting) begin
      if (period_end) begin
        cnt_d = '0;
        bit_d = (tx_bits_done || rx_bits_done) ? '0 : bit_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
      end
    end
    sclk_d = shifting && (cnt_d >= CntW'(SCLK_HALF));
  end

  always_comb begin
    dly_d = dly_q;
    if (delay_clear) begin
      dly_d = '0;
    end else if (delay_en) begin
      dly_d = dly_q + 1'b1;
    end
  end

  // MOSI advances on the cycle SCLK falls and returns to 0 once the command is out.
  always_comb begin
    tx_shift_d = tx_shift_q;
    mosi_d     = 1'b0;
    if (tx_load) begin
      tx_shift_d = tx_buffer_i;
      mosi_d     = tx_buffer_i[TX_BITS-1];
    end else if (tx_en) begin
      if (period_end) begin
        tx_shift_d = tx_shift_q << 1;
      end
      if (!tx_bits_done) begin
        mosi_d = tx_shift_d[TX_BITS-1];
      end
    end
  end

  always_comb begin
    rx_shift_d = rx_shift_q;
    if (tx_load) begin
      rx_shift_d = '0;
    end else if (rx_en && sclk_rise) begin
      rx_shift_d = {rx_shift_q[RX_BITS-2:0], MISO_i};
    end
    rx_buf_d = rx_bits_done ? rx_shift_q : rx_buf_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q      <= '0;
      bit_q      <= '0;
      dly_q      <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_buf_q   <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      dly_q      <= dly_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
    end
  end

  spi_fsm fsm (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .tx_bits_done_i (tx_bits_done),
    .delay_last_i   (delay_last),
    .rx_bits_done_i (rx_bits_done),
    .tx_load_o      (tx_load),
    .tx_en_o        (tx_en),
    .rx_en_o        (rx_en),
    .delay_en_o     (delay_en),
    .delay_clear_o  (delay_clear),
    .cs_n_o         (cs_n),
    .start_o        (start_o),
    .tx_done_o      (tx_done_o),
    .delay_done_o   (delay_done_o),
    .rx_done_o      (rx_done_o),
    .done_o         (done_o)
  );

  assign rx_buffer_o = rx_buf_q;
  assign MOSI_o      = mosi_q;
  assign SCLK_o      = sclk_q;
  assign CS_o        = cs_n;

endmodule

// File: tb/tb_spi.sv
// Bench for the SPI master: behavioural slave plus bus monitor, checked against
// latencies and bit orders derived directly from the protocol description.
module tb_spi;

  localparam int unsigned H       = 4;
  localparam int unsigned TXB     = 8;
  localparam int unsigned RXB     = 24;
  localparam int unsigned DLY     = 64;
  localparam int          LATENCY = 1 + 2 * H * TXB + DLY + 2 * H * RXB;

  logic            clk = 1'b0;
  logic            rst;
  logic            start = 1'b0;
  logic [7:0]      tx_buffer = '0;
  logic [23:0]     rx_buffer;
  logic            miso = 1'b0;
  logic            mosi, cs, sclk, done, start_p, tx_done, delay_done, rx_done;
  logic            h_tx_en = 1'b0, h_tx_load = 1'b0, h_rx_en = 1'b0;
  logic            h_delay_en = 1'b0, h_delay_clear = 1'b0;

  spi #(
    .SCLK_HALF    (H),
    .TX_BITS      (TXB),
    .RX_BITS      (RXB),
    .DELAY_CYCLES (DLY)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .start_i       (start),
    .tx_buffer_i   (tx_buffer),
    .rx_buffer_o   (rx_buffer),
    .MISO_i        (miso),
    .MOSI_o        (mosi),
    .CS_o          (cs),
    .SCLK_o        (sclk),
    .done_o        (done),
    .start_o       (start_p),
    .tx_done_o     (tx_done),
    .delay_done_o  (delay_done),
    .rx_done_o     (rx_done),
    .tx_en_i       (h_tx_en),
    .tx_load_i     (h_tx_load),
    .rx_en_i       (h_rx_en),
    .delay_en_i    (h_delay_en),
    .delay_clear_i (h_delay_clear)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Monitor / slave state, written only by the monitor process.
  int   cyc = 0;
  int   start_cnt = 0, txd_cnt = 0, dd_cnt = 0, rxd_cnt = 0, done_cnt = 0;
  int   start_cyc = 0, txd_cyc = 0, dd_cyc = 0, done_cyc = 0;
  int   cs_viol = 0, dly_viol = 0, idle_viol = 0;
  bit   busy = 1'b0, in_delay = 1'b0;
  logic sclk_prev = 1'b0;
  int   rise_cnt = 0, fall_cnt = 0;
  logic mosi_bits[$];
  logic [23:0] slave_word = '0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst) begin
      busy     = 1'b0;
      in_delay = 1'b0;
    end
    if (start_p)    begin start_cnt++; start_cyc = cyc; end
    if (tx_done)    begin txd_cnt++;   txd_cyc   = cyc; end
    if (delay_done) begin dd_cnt++;    dd_cyc    = cyc; end
    if (rx_done)    rxd_cnt++;
    if (done)       begin done_cnt++;  done_cyc  = cyc; end
    if (rx_done) busy = 1'b0;
    if (start_p) busy = 1'b1;
    if (busy && cs) cs_viol++;
    if (tx_done) in_delay = 1'b1;
    if (in_delay && (sclk || cs)) dly_viol++;
    if (delay_done) in_delay = 1'b0;
    if (cs && sclk) idle_viol++;
    if (cs) begin
      rise_cnt = 0;
      fall_cnt = 0;
    end else begin
      if (!sclk_prev && sclk) begin
        if (rise_cnt < TXB) mosi_bits.push_back(mosi);
        rise_cnt++;
      end
      if (sclk_prev && !sclk) begin
        fall_cnt++;
        if (fall_cnt >= TXB && fall_cnt < TXB + RXB)
          miso = slave_word[RXB - 1 - (fall_cnt - TXB)];
      end
    end
    sclk_prev = sclk;
  end

  task automatic kick(input logic [7:0] cmd, input logic [23:0] word);
    @(negedge clk);
    slave_word    = word;
    tx_buffer     = cmd;
    {h_tx_en, h_tx_load, h_rx_en, h_delay_en, h_delay_clear} = 5'($urandom);
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  task automatic wait_done(input int base, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_cnt != base) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int snap;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL reset_cs got=%b want=1", cs); end
    tests++; if (sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    tests++; if (mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi got=%b want=0", mosi); end
    tests++;
    if (rx_buffer !== 24'h0) begin fails++; $display("FAIL reset_rx got=%h want=0", rx_buffer); end
    tests++;
    if ({done, start_p, tx_done, delay_done, rx_done} !== 5'b0) begin
      fails++; $display("FAIL reset_pulses got=%b want=00000",
                        {done, start_p, tx_done, delay_done, rx_done});
    end
    snap = start_cnt + txd_cnt + dd_cnt + rxd_cnt + done_cnt;
    repeat (100) @(negedge clk);
    tests++;
    if (start_cnt + txd_cnt + dd_cnt + rxd_cnt + done_cnt != snap || cs !== 1'b1) begin
      fails++; $display("FAIL idle_quiet pulses=%0d cs=%b want pulses=%0d cs=1",
                        start_cnt + txd_cnt + dd_cnt + rxd_cnt + done_cnt, cs, snap);
    end
  endtask

  task automatic test_command();
    int mb = mosi_bits.size();
    int tb = txd_cnt;
    int cv = cs_viol;
    int db = done_cnt;
    bit to;
    logic [7:0] cmd = 8'hA5;
    kick(cmd, 24'h5A5A5A);
    wait_done(db, to);
    tests++; if (to) begin fails++; $display("FAIL cmd_timeout got=timeout want=done"); end
    tests++;
    if (mosi_bits.size() - mb != TXB) begin
      fails++; $display("FAIL cmd_rises got=%0d want=%0d", mosi_bits.size() - mb, TXB);
    end else begin
      for (int i = 0; i < TXB; i++) begin
        tests++;
        if (mosi_bits[mb + i] !== cmd[TXB - 1 - i]) begin
          fails++; $display("FAIL cmd_bit%0d got=%b want=%b", i, mosi_bits[mb + i],
                            cmd[TXB - 1 - i]);
        end
      end
    end
    tests++;
    if (txd_cnt - tb != 1) begin fails++; $display("FAIL tx_done_once got=%0d want=1", txd_cnt - tb); end
    tests++;
    if (cs_viol != cv) begin fails++; $display("FAIL cmd_cs_low got=%0d want=%0d", cs_viol, cv); end
  endtask

  task automatic test_full_read();
    int db = done_cnt;
    int dv = dly_viol;
    bit to;
    kick(8'($urandom), 24'hDECADE);
    wait_done(db, to);
    tests++; if (to) begin fails++; $display("FAIL read_timeout got=timeout want=done"); end
    tests++;
    if (done_cnt - db != 1) begin fails++; $display("FAIL read_done_once got=%0d want=1", done_cnt - db); end
    tests++;
    if (done_cyc - start_cyc != LATENCY) begin
      fails++; $display("FAIL read_latency got=%0d want=%0d", done_cyc - start_cyc, LATENCY);
    end
    tests++;
    if (rx_buffer !== 24'hDECADE) begin fails++; $display("FAIL read_data got=%h want=decade", rx_buffer); end
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL read_cs_after got=%b want=1", cs); end
    tests++;
    if (dd_cyc - txd_cyc != DLY) begin
      fails++; $display("FAIL delay_len got=%0d want=%0d", dd_cyc - txd_cyc, DLY);
    end
    tests++;
    if (dly_viol != dv) begin fails++; $display("FAIL delay_idle got=%0d want=%0d", dly_viol, dv); end
  endtask

  task automatic test_random_reads();
    for (int n = 0; n < 4; n++) begin
      logic [7:0]  cmd = 8'($urandom);
      logic [23:0] word = 24'($urandom);
      logic [7:0]  got = '0;
      int mb = mosi_bits.size();
      int db = done_cnt;
      bit to;
      kick(cmd, word);
      wait_done(db, to);
      tests++; if (to) begin fails++; $display("FAIL rand%0d_timeout got=timeout want=done", n); end
      for (int i = 0; i < TXB; i++)
        if (mb + i < mosi_bits.size()) got = {got[6:0], mosi_bits[mb + i]};
      tests++; if (got !== cmd) begin fails++; $display("FAIL rand%0d_cmd got=%h want=%h", n, got, cmd); end
      tests++;
      if (rx_buffer !== word) begin fails++; $display("FAIL rand%0d_rx got=%h want=%h", n, rx_buffer, word); end
      tests++;
      if (done_cyc - start_cyc != LATENCY) begin
        fails++; $display("FAIL rand%0d_latency got=%0d want=%0d", n, done_cyc - start_cyc, LATENCY);
      end
    end
  endtask

  task automatic test_busy_start();
    int db = done_cnt;
    int sb = start_cnt;
    int ddb = dd_cnt;
    bit to;
    kick(8'h3C, 24'hABCDEF);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dd_cnt != ddb) break;
    end
    tests++; if (dd_cnt == ddb) begin fails++; $display("FAIL busy_reach_rx got=none want=delay_done"); end
    repeat (40) @(negedge clk);
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done(db, to);
    tests++; if (to) begin fails++; $display("FAIL busy_timeout got=timeout want=done"); end
    tests++;
    if (start_cnt - sb != 1) begin fails++; $display("FAIL busy_starts got=%0d want=1", start_cnt - sb); end
    tests++;
    if (rx_buffer !== 24'hABCDEF) begin fails++; $display("FAIL busy_rx got=%h want=abcdef", rx_buffer); end
    tests++;
    if (done_cyc - start_cyc != LATENCY) begin
      fails++; $display("FAIL busy_latency got=%0d want=%0d", done_cyc - start_cyc, LATENCY);
    end
    db = done_cnt;
    kick(8'($urandom), 24'h123456);
    wait_done(db, to);
    tests++;
    if (to || rx_buffer !== 24'h123456) begin
      fails++; $display("FAIL second_read got=%h want=123456 timeout=%0d", rx_buffer, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] w1 = 24'($urandom);
    logic [23:0] w2 = 24'($urandom);
    int db = done_cnt;
    int sb = start_cnt;
    bit to;
    @(negedge clk);
    slave_word = w1;
    tx_buffer  = 8'($urandom);
    start      = 1'b1;
    wait_done(db, to);
    tests++;
    if (to || rx_buffer !== w1) begin
      fails++; $display("FAIL b2b_first got=%h want=%h timeout=%0d", rx_buffer, w1, to);
    end
    @(negedge clk);
    start      = 1'b0;
    slave_word = w2;
    tests++;
    if (start_cnt - sb != 2 || start_cyc - done_cyc != 1) begin
      fails++; $display("FAIL b2b_restart got=starts %0d gap %0d want=starts 2 gap 1",
                        start_cnt - sb, start_cyc - done_cyc);
    end
    wait_done(db + 1, to);
    tests++;
    if (to || rx_buffer !== w2) begin
      fails++; $display("FAIL b2b_second got=%h want=%h timeout=%0d", rx_buffer, w2, to);
    end
  endtask

  task automatic test_reset_mid();
    int db = done_cnt;
    int ddb = dd_cnt;
    logic [23:0] word = 24'($urandom) | 24'h1;
    bit to;
    kick(8'($urandom), 24'($urandom));
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dd_cnt != ddb) break;
    end
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (cs !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
      fails++; $display("FAIL midreset_bus got=cs%b sclk%b mosi%b want=cs1 sclk0 mosi0",
                        cs, sclk, mosi);
    end
    tests++;
    if (rx_buffer !== 24'h0) begin fails++; $display("FAIL midreset_rx got=%h want=0", rx_buffer); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt != db) begin fails++; $display("FAIL midreset_no_done got=%0d want=%0d", done_cnt, db); end
    kick(8'($urandom), word);
    wait_done(db, to);
    tests++;
    if (to || rx_buffer !== word) begin
      fails++; $display("FAIL after_reset_rx got=%h want=%h timeout=%0d", rx_buffer, word, to);
    end
    tests++;
    if (done_cyc - start_cyc != LATENCY) begin
      fails++; $display("FAIL after_reset_latency got=%0d want=%0d", done_cyc - start_cyc, LATENCY);
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (cs_viol != 0 || dly_viol != 0 || idle_viol != 0) begin
      fails++; $display("FAIL bus_invariants got=cs%0d dly%0d idle%0d want=0 0 0",
                        cs_viol, dly_viol, idle_viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_command();
    test_full_read();
    test_random_reads();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
